// File: rtl/fifo_frame_reader_if.sv
// Read-side bundle for fifo_frame_reader: FIFO pull port plus the framed
// valid/ready sample stream toward the FFT.
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_first;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_first, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_first, m_last
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Pulls samples from the async FIFO read port and re-emits them as FRAME_LEN
// blocks on a valid/ready stream; FIFO_FRAME_READER_STATS_EN adds underrun_cnt.
module fifo_frame_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 64,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   enable,
  fifo_frame_reader_if.master    bus,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy,
  output logic [15:0]            underrun_cnt
);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} state_t;

  state_t                  state_q, state_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              occ_q, occ_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic [DATA_WIDTH-1:0]   data_q [2];
  logic [DATA_WIDTH-1:0]   data_d [2];
  logic [1:0]              first_q, first_d;
  logic [1:0]              last_q, last_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic                    pop;
  logic                    run_ok;
  logic                    issue_ok;
  logic                    accept;
  logic                    drained;
  logic [1:0]              fill_nxt;
  logic [IDX_W-1:0]        cap_idx;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign pop      = (occ_q != 2'd0) && bus.m_ready;
  assign run_ok   = (state_q == ACTIVE) || ((state_q == STOPPING) && (rd_idx_q != '0));
  // Entries committed after this edge: buffered + in flight - leaving now.
  assign fill_nxt = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue_ok = run_ok && (fill_nxt < 2'd2);
  assign accept   = issue_ok && !bus.fifo_empty;
  assign drained  = (rd_idx_q == '0) && !inflight_q && (occ_q == 2'd0) && (out_idx_q == '0);
  // The sample landing now sits behind whatever is still buffered ahead of it.
  assign cap_idx  = (occ_q == 2'd0) ? out_idx_q : idx_inc(out_idx_q);

  always_comb begin
    data_d  = data_q;
    first_d = first_q;
    last_d  = last_q;
    occ_d   = fill_nxt;
    if (pop) begin
      data_d[0]  = data_q[1];
      first_d[0] = first_q[1];
      last_d[0]  = last_q[1];
    end
    if (inflight_q) begin
      if ((occ_q == 2'd0) || pop) begin
        data_d[0]  = bus.fifo_rd_data;
        first_d[0] = (cap_idx == '0);
        last_d[0]  = (cap_idx == LAST_IDX);
      end else begin
        data_d[1]  = bus.fifo_rd_data;
        first_d[1] = (cap_idx == '0);
        last_d[1]  = (cap_idx == LAST_IDX);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    inflight_d  = accept;
    rd_idx_d    = accept ? idx_inc(rd_idx_q) : rd_idx_q;
    out_idx_d   = pop ? idx_inc(out_idx_q) : out_idx_q;
    frame_cnt_d = (pop && last_q[0]) ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_d = (drained && !accept) ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (enable)       state_d = ACTIVE;
        else if (drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      first_q     <= 2'b00;
      last_q      <= 2'b00;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      data_q[0]   <= data_d[0];
      data_q[1]   <= data_d[1];
      first_q     <= first_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.fifo_rd_en = accept;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = data_q[0];
  assign bus.m_first    = first_q[0];
  assign bus.m_last     = last_q[0];
  assign frame_cnt      = frame_cnt_q;
  assign busy           = (state_q != IDLE);

`ifdef FIFO_FRAME_READER_STATS_EN
  logic [15:0] under_q, under_d;
  logic        under_evt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A stall only counts when the buffer had room, i.e. the FIFO is the bottleneck.
  assign under_evt = ((state_q == ACTIVE) || (state_q == STOPPING)) && (rd_idx_q != '0) &&
                     bus.fifo_empty && ((occ_q + {1'b0, inflight_q}) < 2'd2);
  assign under_d   = under_evt ? sat_inc16(under_q) : under_q;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) under_q <= 16'h0000;
    else           under_q <= under_d;
  end

  assign underrun_cnt = under_q;
`else
  assign underrun_cnt = 16'h0000;
`endif
endmodule
